pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-002 Port: clk  in  1  pipeline clock, rising edge.
REQ-003 Port: rst  in  1  asynchronous active-high reset.
REQ-004 Port: IfIdRs, IfIdRt  in  5 each  source registers of the instruction in ID.
REQ-005 Port: IfId_isBranchUse  in  1  the ID instruction is BEQ, BNE, JR or JALR, and its operands are compared in ID.
REQ-006 Port: IfId_usesRt  in  1  the ID instruction reads Rt.
REQ-007 Port: IdEx_MemRead, IdEx_RegWrite  in  1 each  EX-stage load flag and write-back flag.
REQ-008 Port: IdExWr  in  5  EX-stage destination register.
REQ-009 Port: ExMem_MemRead  in  1  MEM-stage load flag.
REQ-010 Port: ExMemRd  in  5  MEM-stage destination register.
REQ-011 Port: ICache_stall, DCache_stall  in  1 each  memory not ready.
REQ-012 Port: Redirect  in  1  branch taken or jump resolved in ID this cycle.
REQ-013 Port: PC_write, IfId_write, IdEx_write, ExMem_write, MemWb_write  out  1 each  pipeline register enables.
REQ-014 Port: IfId_flush, IdEx_bubble  out  1 each  zero the IF/ID register; insert a NOP into ID/EX.
REQ-015 Port: stall_cycles  out  16  saturating count of hazard plus memory stall cycles.

Function
REQ-016 Definition: match(r) = (r != 0) && (r == IfIdRs || (IfId_usesRt && r == IfIdRt)).
REQ-017 The FSM SHALL have exactly the states RUN, HZ2 and HZ1, which are encoded in 2 bits; the illegal encoding SHALL go to RUN.
REQ-018 Memory freeze SHALL have the highest priority: while ICache_stall || DCache_stall, all five enables = 0, IfId_flush = 0, IdEx_bubble = 0, and the FSM state holds.
REQ-019 In RUN, with no freeze, the block SHALL check hazards in this order (first match wins):
  - IfId_isBranchUse && IdEx_MemRead && match(IdExWr): 2-cycle hazard; next state HZ1.
  - IfId_isBranchUse && IdEx_RegWrite && match(IdExWr): 1-cycle hazard; next state RUN.
  - IfId_isBranchUse && ExMem_MemRead && match(ExMemRd): 1-cycle hazard; next state RUN.
  - IdEx_MemRead && match(IdExWr) (load-use): 1-cycle hazard; next state RUN.
REQ-020 During any hazard cycle, the block SHALL drive PC_write = 0, IfId_write = 0, IdEx_bubble = 1, and IdEx_write = ExMem_write = MemWb_write = 1.
REQ-021 In HZ1, with no freeze, the block SHALL drive the stall outputs of REQ-020 unconditionally, ignore the hazard inputs, and go to RUN next.
REQ-022 HZ2 is reserved for a 3-cycle extension: it SHALL behave as a hazard cycle and go to HZ1.
REQ-023 With no hazard and no freeze, all enables SHALL be 1 and IdEx_bubble SHALL be 0.
REQ-024 IfId_flush SHALL be 1 only when Redirect = 1 in a non-hazard, non-freeze cycle; a Redirect during a stall SHALL be ignored, because ID re-evaluates it after the stall.
REQ-025 IfId_flush and IdEx_bubble SHALL never both be 1.
REQ-026 All outputs except stall_cycles SHALL be combinational from the state and the inputs, with zero-cycle latency.
REQ-027 stall_cycles SHALL increment by 1 on each clock edge where PC_write was 0 and rst = 0, and SHALL saturate at 16'hFFFF (no wrap).

Reset
REQ-028 While rst = 1, the block SHALL hold state = RUN and stall_cycles = 0, and drive all enables = 0, IfId_flush = 0 and IdEx_bubble = 0, regardless of the other inputs.
REQ-029 The reset SHALL take effect asynchronously; it SHALL be removed synchronously to the first clk edge after deassertion, and the first post-reset cycle SHALL be evaluated from RUN.
REQ-030 A reset asserted in HZ1 SHALL abort the remaining stall; no residual bubble SHALL be issued after the release.

Verification
REQ-031 Load-use: IdEx_MemRead = 1, IdExWr = 8, IfIdRs = 8 -> one cycle with PC_write = 0 and IdEx_bubble = 1, then all enables = 1; stall_cycles = 1.
REQ-032 Branch after load: IfId_isBranchUse = 1, IdEx_MemRead = 1, IdExWr = 9, IfIdRt = 9, IfId_usesRt = 1, then inputs cleared -> exactly 2 stall cycles (RUN, then HZ1, then RUN); stall_cycles = 2.
REQ-033 $zero: IdEx_MemRead = 1, IdExWr = 0, IfIdRs = 0 -> no stall; PC_write = 1.
REQ-034 Freeze inside HZ1: DCache_stall = 1 for 3 cycles while in HZ1 -> all enables = 0 for those 3 cycles with the state held, then one hazard cycle, then RUN; stall_cycles = 5 (including the initial hazard cycle).
REQ-035 Redirect: Redirect = 1 with no hazard -> IfId_flush = 1 for one cycle; Redirect = 1 during a load-use stall -> IfId_flush = 0.
REQ-036 Saturation and reset: force a continuous stall for more than 65535 cycles -> stall_cycles = 16'hFFFF and holds; asserting rst mid-HZ1 -> outputs = 0 immediately, and RUN with stall_cycles = 0 after the release.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Hazard / memory-stall controller for a 5-stage pipeline with branch operands compared in ID.
// Drives the pipeline register enables, the IF/ID flush, the ID/EX bubble, and a saturating stall counter.
module pipeline_stall_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IfIdRs,
  input  logic [4:0]  IfIdRt,
  input  logic        IfId_isBranchUse,
  input  logic        IfId_usesRt,
  input  logic        IdEx_MemRead,
  input  logic        IdEx_RegWrite,
  input  logic [4:0]  IdExWr,
  input  logic        ExMem_MemRead,
  input  logic [4:0]  ExMemRd,
  input  logic        ICache_stall,
  input  logic        DCache_stall,
  input  logic        Redirect,
  output logic        PC_write,
  output logic        IfId_write,
  output logic        IdEx_write,
  output logic        ExMem_write,
  output logic        MemWb_write,
  output logic        IfId_flush,
  output logic        IdEx_bubble,
  output logic [15:0] stall_cycles,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] RUN = 2'b00;
  localparam logic [1:0] HZ1 = 2'b01;
  localparam logic [1:0] HZ2 = 2'b10;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       freeze;
  logic       m_idex;
  logic       m_exmem;
  logic       long_hz;
  logic       short_hz;
  logic       hazard;

  // A register number that is non-zero and read by the ID instruction.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

  always_comb begin
    freeze   = ICache_stall | DCache_stall;
    m_idex   = reg_match(IdExWr, IfIdRs, IfIdRt, IfId_usesRt);
    m_exmem  = reg_match(ExMemRd, IfIdRs, IfIdRt, IfId_usesRt);
    long_hz  = IfId_isBranchUse & IdEx_MemRead & m_idex;
    short_hz = (IfId_isBranchUse & IdEx_RegWrite & m_idex)
             | (IfId_isBranchUse & ExMem_MemRead & m_exmem)
             | (IdEx_MemRead & m_idex);
  end

  // The illegal encoding is decoded like RUN for outputs but always recovers to RUN.
  always_comb begin
    hazard   = 1'b0;
    state_nx = RUN;
    case (state)
      RUN: begin
        hazard   = long_hz | short_hz;
        state_nx = freeze ? RUN : (long_hz ? HZ1 : RUN);
      end
      HZ1: begin
        hazard   = 1'b1;
        state_nx = freeze ? HZ1 : RUN;
      end
      HZ2: begin
        hazard   = 1'b1;
        state_nx = freeze ? HZ2 : HZ1;
      end
      default: begin
        hazard   = long_hz | short_hz;
        state_nx = RUN;
      end
    endcase
  end

  // Reset and freeze both force every enable low; Redirect only flushes in a clean cycle.
  always_comb begin
    PC_write    = 1'b0;
    IfId_write  = 1'b0;
    IdEx_write  = 1'b0;
    ExMem_write = 1'b0;
    MemWb_write = 1'b0;
    IfId_flush  = 1'b0;
    IdEx_bubble = 1'b0;
    if (!rst && !freeze) begin
      IdEx_write  = 1'b1;
      ExMem_write = 1'b1;
      MemWb_write = 1'b1;
      if (hazard) begin
        IdEx_bubble = 1'b1;
      end else begin
        PC_write   = 1'b1;
        IfId_write = 1'b1;
        IfId_flush = Redirect;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (!PC_write && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: table-driven scenarios, expected outputs queued per cycle.
module tb_pipeline_stall_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       ur;
    logic       imr;
    logic       irw;
    logic [4:0] iwr;
    logic       emr;
    logic [4:0] erd;
    logic       ic;
    logic       dc;
    logic       rd;
  } stim_t;

  // Expected vector: {PC, IfId, IdEx, ExMem, MemWb enables, flush, bubble, state[1:0]}
  localparam logic [6:0] O_RUN   = 7'b11111_00;
  localparam logic [6:0] O_HAZ   = 7'b00111_01;
  localparam logic [6:0] O_FRZ   = 7'b00000_00;
  localparam logic [6:0] O_FLUSH = 7'b11111_10;
  localparam logic [1:0] S_RUN   = 2'b00;
  localparam logic [1:0] S_HZ1   = 2'b01;

  logic        clk;
  logic        rst;
  stim_t       stim;
  logic        PC_write, IfId_write, IdEx_write, ExMem_write, MemWb_write;
  logic        IfId_flush, IdEx_bubble;
  logic [15:0] stall_cycles;
  logic [1:0]  state_dbg;
  logic [8:0]  outs;
  logic [8:0]  got;
  logic [8:0]  exp_v;
  logic [8:0]  exp_q[$];
  int          n_cmp;
  int          n_err;

  pipeline_stall_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .IfIdRs           (stim.rs),
    .IfIdRt           (stim.rt),
    .IfId_isBranchUse (stim.br),
    .IfId_usesRt      (stim.ur),
    .IdEx_MemRead     (stim.imr),
    .IdEx_RegWrite    (stim.irw),
    .IdExWr           (stim.iwr),
    .ExMem_MemRead    (stim.emr),
    .ExMemRd          (stim.erd),
    .ICache_stall     (stim.ic),
    .DCache_stall     (stim.dc),
    .Redirect         (stim.rd),
    .PC_write         (PC_write),
    .IfId_write       (IfId_write),
    .IdEx_write       (IdEx_write),
    .ExMem_write      (ExMem_write),
    .MemWb_write      (MemWb_write),
    .IfId_flush       (IfId_flush),
    .IdEx_bubble      (IdEx_bubble),
    .stall_cycles     (stall_cycles),
    .state_dbg        (state_dbg)
  );

  assign outs = {PC_write, IfId_write, IdEx_write, ExMem_write, MemWb_write,
                 IfId_flush, IdEx_bubble, state_dbg};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst  = 1'b1;
    stim = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver ----------------
  function automatic stim_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic br,
                               input logic ur, input logic imr, input logic irw,
                               input logic [4:0] iwr, input logic emr, input logic [4:0] erd,
                               input logic ic, input logic dc, input logic rd);
    stim_t s;
    s = '{rs: rs, rt: rt, br: br, ur: ur, imr: imr, irw: irw, iwr: iwr,
          emr: emr, erd: erd, ic: ic, dc: dc, rd: rd};
    return s;
  endfunction

  task automatic drive(input stim_t s, input logic [8:0] e);
    stim = s;
    exp_q.push_back(e);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst  = 1'b1;
    stim = mk(5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({O_FRZ, S_RUN});
      #2;
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL reset_outs[%0d]: got %b expected %b", i, got, exp_v);
      end
      n_cmp++;
      if (stall_cycles !== 16'd0) begin
        n_err++; $display("FAIL reset_count[%0d]: got %0d expected 0", i, stall_cycles);
      end
      @(negedge clk);
    end
    rst  = 1'b0;
    stim = '0;
  endtask

  task automatic test_load_use();
    stim_t s[4];
    logic [8:0] e[4];
    do_reset();
    s[0] = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[0] = {O_HAZ, S_RUN};
    s[1] = '0;                                                                        e[1] = {O_RUN, S_RUN};
    s[2] = mk(5'd3, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[2] = {O_HAZ, S_RUN};
    s[3] = '0;                                                                        e[3] = {O_RUN, S_RUN};
    for (int i = 0; i < 4; i++) begin
      drive(s[i], e[i]);
      #2;
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL load_use[%0d]: got %b expected %b", i, got, exp_v);
      end
      if (i == 1) begin
        n_cmp++;
        if (stall_cycles !== 16'd1) begin
          n_err++; $display("FAIL load_use_count: got %0d expected 1", stall_cycles);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_load();
    stim_t s[3];
    logic [8:0] e[3];
    do_reset();
    s[0] = mk(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[0] = {O_HAZ, S_RUN};
    s[1] = '0;                                                                        e[1] = {O_HAZ, S_HZ1};
    s[2] = '0;                                                                        e[2] = {O_RUN, S_RUN};
    for (int i = 0; i < 3; i++) begin
      drive(s[i], e[i]);
      #2;
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL branch_load[%0d]: got %b expected %b", i, got, exp_v);
      end
      @(negedge clk);
    end
    #2;
    n_cmp++;
    if (stall_cycles !== 16'd2) begin
      n_err++; $display("FAIL branch_load_count: got %0d expected 2", stall_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_branch_hazards();
    stim_t s[10];
    logic [8:0] e[10];
    do_reset();
    s[0] = mk(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[0] = {O_HAZ, S_RUN};
    s[1] = '0;                                                                        e[1] = {O_RUN, S_RUN};
    s[2] = mk(5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); e[2] = {O_HAZ, S_RUN};
    s[3] = '0;                                                                        e[3] = {O_RUN, S_RUN};
    s[4] = mk(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[4] = {O_RUN, S_RUN};
    s[5] = mk(5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0); e[5] = {O_RUN, S_RUN};
    s[6] = mk(5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[6] = {O_RUN, S_RUN};
    s[7] = mk(5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[7] = {O_RUN, S_RUN};
    s[8] = mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); e[8] = {O_RUN, S_RUN};
    s[9] = mk(5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[9] = {O_RUN, S_RUN};
    for (int i = 0; i < 10; i++) begin
      drive(s[i], e[i]);
      #2;
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL branch_hazards[%0d]: got %b expected %b", i, got, exp_v);
      end
      @(negedge clk);
    end
    #2;
    n_cmp++;
    if (stall_cycles !== 16'd2) begin
      n_err++; $display("FAIL branch_hazards_count: got %0d expected 2", stall_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_freeze_hz1();
    stim_t s[9];
    logic [8:0] e[9];
    do_reset();
    s[0] = mk(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[0] = {O_HAZ, S_RUN};
    s[1] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); e[1] = {O_FRZ, S_HZ1};
    s[2] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); e[2] = {O_FRZ, S_HZ1};
    s[3] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); e[3] = {O_FRZ, S_HZ1};
    s[4] = '0;                                                                        e[4] = {O_HAZ, S_HZ1};
    s[5] = '0;                                                                        e[5] = {O_RUN, S_RUN};
    s[6] = mk(5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1); e[6] = {O_FRZ, S_RUN};
    s[7] = mk(5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); e[7] = {O_HAZ, S_RUN};
    s[8] = '0;                                                                        e[8] = {O_RUN, S_RUN};
    for (int i = 0; i < 9; i++) begin
      drive(s[i], e[i]);
      #2;
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL freeze_hz1[%0d]: got %b expected %b", i, got, exp_v);
      end
      if (i == 5) begin
        n_cmp++;
        if (stall_cycles !== 16'd5) begin
          n_err++; $display("FAIL freeze_hz1_count: got %0d expected 5", stall_cycles);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    stim_t s[4];
    logic [8:0] e[4];
    do_reset();
    s[0] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); e[0] = {O_FLUSH, S_RUN};
    s[1] = '0;                                                                        e[1] = {O_RUN, S_RUN};
    s[2] = mk(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); e[2] = {O_HAZ, S_RUN};
    s[3] = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); e[3] = {O_FLUSH, S_RUN};
    for (int i = 0; i < 4; i++) begin
      drive(s[i], e[i]);
      #2;
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL redirect[%0d]: got %b expected %b", i, got, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    stim_t bl;
    stim_t s[5];
    logic [8:0] e[5];
    do_reset();
    bl = mk(5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    s[0] = bl; e[0] = {O_HAZ, S_RUN};
    s[1] = bl; e[1] = {O_HAZ, S_HZ1};
    s[2] = bl; e[2] = {O_HAZ, S_RUN};
    s[3] = '0; e[3] = {O_HAZ, S_HZ1};
    s[4] = '0; e[4] = {O_RUN, S_RUN};
    for (int i = 0; i < 5; i++) begin
      drive(s[i], e[i]);
      #2;
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, exp_v);
      end
      @(negedge clk);
    end
    #2;
    n_cmp++;
    if (stall_cycles !== 16'd4) begin
      n_err++; $display("FAIL back_to_back_count: got %0d expected 4", stall_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hz1();
    do_reset();
    drive(mk(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), {O_HAZ, S_RUN});
    drive('0, {O_HAZ, S_HZ1});
    drive('0, {O_FRZ, S_RUN});
    drive('0, {O_RUN, S_RUN});
    drive('0, {O_RUN, S_RUN});
    stim = mk(5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) stim = '0;
      if (i == 2) begin
        #1 rst = 1'b1;
        #1;
      end else begin
        #2;
      end
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL reset_mid_hz1[%0d]: got %b expected %b", i, got, exp_v);
      end
      if (i >= 2) begin
        n_cmp++;
        if (stall_cycles !== 16'd0) begin
          n_err++; $display("FAIL reset_mid_hz1_count[%0d]: got %0d expected 0", i, stall_cycles);
        end
      end
      @(negedge clk);
      if (i == 2) rst = 1'b0;
    end
  endtask

  task automatic test_saturation();
    int extra;
    do_reset();
    stim = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    n_cmp++;
    if (stall_cycles !== 16'd100) begin
      n_err++; $display("FAIL saturation_partial: got %0d expected 100", stall_cycles);
    end
    extra = $urandom_range(10, 200);
    repeat (65435 + extra) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({O_FRZ, S_RUN});
      #2;
      got = outs; exp_v = exp_q.pop_front(); n_cmp++;
      if (got !== exp_v) begin
        n_err++; $display("FAIL saturation_outs[%0d]: got %b expected %b", i, got, exp_v);
      end
      n_cmp++;
      if (stall_cycles !== 16'hFFFF) begin
        n_err++; $display("FAIL saturation_count[%0d]: got %h expected ffff", i, stall_cycles);
      end
      @(negedge clk);
    end
    stim = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    stim  = '0;
    test_reset();
    @(negedge clk);
    test_load_use();
    test_branch_load();
    test_branch_hazards();
    test_freeze_hz1();
    test_redirect();
    test_back_to_back();
    test_reset_mid_hz1();
    test_saturation();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
